// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID->EX pipeline register of the 19-bit CPU.
//   * Captures the decoded operands and control of the ID instruction into the
//     EX stage, one cycle after capture.
//   * Detects load-use hazards against the load currently in EX. It raises
//     `stall` to hold PC and IF/ID, and inserts a single bubble into EX.
//   * Bypasses a same-cycle WB register write into the captured operand data.
//   * Counts hazard bubbles in a saturating performance counter.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   id_valid                     ID holds a real instruction
//   id_rs/id_rt/id_rd            decoded register addresses
//   id_uses_rs/id_uses_rt        instruction really reads rs / rt
//   id_rs_data/id_rt_data        register-file read data
//   id_imm                       sign-extended immediate
//   id_alu_op, id_alusrc,
//   id_regwrite, id_memread,
//   id_memwrite, id_memtoreg     decoded control
//   wb_regwrite/wb_rd/wb_data    WB write port, used for the operand bypass
//   flush                        taken branch/jump in EX; kill the ID instruction
//   ex_hold                      downstream stall; freeze this stage
//   stall                        combinational; hold PC and IF/ID
//   ex_*                         registered EX-stage fields
//   bubble_cnt                   saturating count of hazard bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W  = 19,
   parameter int REG_W   = 3,
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [REG_W-1:0]   id_rs,
   input  logic [REG_W-1:0]   id_rt,
   input  logic [REG_W-1:0]   id_rd,
   input  logic               id_uses_rs,
   input  logic               id_uses_rt,
   input  logic [DATA_W-1:0]  id_rs_data,
   input  logic [DATA_W-1:0]  id_rt_data,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [ALUOP_W-1:0] id_alu_op,
   input  logic               id_alusrc,
   input  logic               id_regwrite,
   input  logic               id_memread,
   input  logic               id_memwrite,
   input  logic               id_memtoreg,
   input  logic               wb_regwrite,
   input  logic [REG_W-1:0]   wb_rd,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic               flush,
   input  logic               ex_hold,
   output logic               stall,
   output logic               ex_valid,
   output logic [REG_W-1:0]   ex_rs,
   output logic [REG_W-1:0]   ex_rt,
   output logic [REG_W-1:0]   ex_rd,
   output logic [DATA_W-1:0]  ex_rs_data,
   output logic [DATA_W-1:0]  ex_rt_data,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_alusrc,
   output logic               ex_regwrite,
   output logic               ex_memread,
   output logic               ex_memwrite,
   output logic               ex_memtoreg,
   output logic [CNT_W-1:0]   bubble_cnt
);

   // WB bypass: a register written by WB in this same cycle is not yet visible
   // in the register-file read data, so take the WB value instead.
   function automatic logic [DATA_W-1:0] wb_bypass(
      input logic              wb_we,
      input logic [REG_W-1:0]  wb_addr,
      input logic [REG_W-1:0]  rd_addr,
      input logic [DATA_W-1:0] wb_val,
      input logic [DATA_W-1:0] rf_val
   );
      logic [DATA_W-1:0] res;
      if (wb_we && (wb_addr == rd_addr)) begin
         res = wb_val;
      end else begin
         res = rf_val;
      end
      return res;
   endfunction

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic               ex_valid_r;
   logic [REG_W-1:0]   ex_rs_r;
   logic [REG_W-1:0]   ex_rt_r;
   logic [REG_W-1:0]   ex_rd_r;
   logic [DATA_W-1:0]  ex_rs_data_r;
   logic [DATA_W-1:0]  ex_rt_data_r;
   logic [DATA_W-1:0]  ex_imm_r;
   logic [ALUOP_W-1:0] ex_alu_op_r;
   logic               ex_alusrc_r;
   logic               ex_regwrite_r;
   logic               ex_memread_r;
   logic               ex_memwrite_r;
   logic               ex_memtoreg_r;
   logic [CNT_W-1:0]   bubble_cnt_r;

   logic               hazard_s;
   logic [DATA_W-1:0]  rs_cap_s;
   logic [DATA_W-1:0]  rt_cap_s;

   // Load-use hazard detection and operand capture selection.
   always_comb begin
      hazard_s = ex_valid_r & ex_memread_r & id_valid &
                 ((id_uses_rs & (ex_rd_r == id_rs)) |
                  (id_uses_rt & (ex_rd_r == id_rt)));
      rs_cap_s = wb_bypass(wb_regwrite, wb_rd, id_rs, wb_data, id_rs_data);
      rt_cap_s = wb_bypass(wb_regwrite, wb_rd, id_rt, wb_data, id_rt_data);
   end

   // The stall request is not gated by ex_hold; a flush discards the consumer,
   // so there is nothing left to stall for.
   assign stall = hazard_s & ~flush;

   // EX pipeline register: reset > flush > hold > hazard bubble > load.
   // Bubbles clear valid, control and register addresses but leave the data
   // and immediate fields untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_r    <= 1'b0;
         ex_rs_r       <= {REG_W{1'b0}};
         ex_rt_r       <= {REG_W{1'b0}};
         ex_rd_r       <= {REG_W{1'b0}};
         ex_rs_data_r  <= {DATA_W{1'b0}};
         ex_rt_data_r  <= {DATA_W{1'b0}};
         ex_imm_r      <= {DATA_W{1'b0}};
         ex_alu_op_r   <= {ALUOP_W{1'b0}};
         ex_alusrc_r   <= 1'b0;
         ex_regwrite_r <= 1'b0;
         ex_memread_r  <= 1'b0;
         ex_memwrite_r <= 1'b0;
         ex_memtoreg_r <= 1'b0;
         bubble_cnt_r  <= {CNT_W{1'b0}};
      end else if (flush || (!ex_hold && hazard_s)) begin
         ex_valid_r    <= 1'b0;
         ex_rs_r       <= {REG_W{1'b0}};
         ex_rt_r       <= {REG_W{1'b0}};
         ex_rd_r       <= {REG_W{1'b0}};
         ex_alu_op_r   <= {ALUOP_W{1'b0}};
         ex_alusrc_r   <= 1'b0;
         ex_regwrite_r <= 1'b0;
         ex_memread_r  <= 1'b0;
         ex_memwrite_r <= 1'b0;
         ex_memtoreg_r <= 1'b0;
         // Only hazard bubbles are counted; flush bubbles are not.
         if (!flush && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
      end else if (ex_hold) begin
         ex_valid_r <= ex_valid_r;
      end else begin
         ex_valid_r    <= id_valid;
         ex_rs_r       <= id_rs;
         ex_rt_r       <= id_rt;
         ex_rd_r       <= id_rd;
         ex_rs_data_r  <= rs_cap_s;
         ex_rt_data_r  <= rt_cap_s;
         ex_imm_r      <= id_imm;
         ex_alu_op_r   <= id_alu_op;
         ex_alusrc_r   <= id_alusrc;
         // An invalid instruction must never write a register or memory.
         ex_regwrite_r <= id_regwrite & id_valid;
         ex_memread_r  <= id_memread  & id_valid;
         ex_memwrite_r <= id_memwrite & id_valid;
         ex_memtoreg_r <= id_memtoreg & id_valid;
      end
   end

   assign ex_valid    = ex_valid_r;
   assign ex_rs       = ex_rs_r;
   assign ex_rt       = ex_rt_r;
   assign ex_rd       = ex_rd_r;
   assign ex_rs_data  = ex_rs_data_r;
   assign ex_rt_data  = ex_rt_data_r;
   assign ex_imm      = ex_imm_r;
   assign ex_alu_op   = ex_alu_op_r;
   assign ex_alusrc   = ex_alusrc_r;
   assign ex_regwrite = ex_regwrite_r;
   assign ex_memread  = ex_memread_r;
   assign ex_memwrite = ex_memwrite_r;
   assign ex_memtoreg = ex_memtoreg_r;
   assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed self-checking bench for id_ex_stage. Inputs are driven 1 time unit
// after the rising edge; outputs are checked there too (registered fields
// reflect the last edge, stall reflects the current inputs).
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [2:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt;
   logic [18:0] id_rs_data, id_rt_data, id_imm;
   logic [3:0]  id_alu_op;
   logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        wb_regwrite;
   logic [2:0]  wb_rd;
   logic [18:0] wb_data;
   logic        flush, ex_hold;
   logic        stall, ex_valid;
   logic [2:0]  ex_rs, ex_rt, ex_rd;
   logic [18:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [3:0]  ex_alu_op;
   logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
   logic [7:0]  bubble_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_alu_op(ex_alu_op), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
      .bubble_cnt(bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Put a load "r5 <- mem[r1]" into ID.
   task automatic drive_load();
      id_valid = 1'b1; id_rs = 3'd1; id_rt = 3'd0; id_rd = 3'd5;
      id_uses_rs = 1'b1; id_uses_rt = 1'b0;
      id_rs_data = 19'h00AAA; id_rt_data = 19'h00000; id_imm = 19'h00004;
      id_alu_op = 4'h1; id_alusrc = 1'b1; id_regwrite = 1'b1;
      id_memread = 1'b1; id_memwrite = 1'b0; id_memtoreg = 1'b1;
   endtask

   // Put an ALU op "r7 <- r5 op r6" into ID.
   task automatic drive_consumer(input logic uses_rs);
      id_valid = 1'b1; id_rs = 3'd5; id_rt = 3'd6; id_rd = 3'd7;
      id_uses_rs = uses_rs; id_uses_rt = 1'b1;
      id_rs_data = 19'h00111; id_rt_data = 19'h00666; id_imm = 19'h00000;
      id_alu_op = 4'h2; id_alusrc = 1'b0; id_regwrite = 1'b1;
      id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_rs = 3'd0; id_rt = 3'd0; id_rd = 3'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_rs_data = 19'h0; id_rt_data = 19'h0;
      id_imm = 19'h0; id_alu_op = 4'h0; id_alusrc = 1'b0; id_regwrite = 1'b0;
      id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = 1'b0;
      wb_regwrite = 1'b0; wb_rd = 3'd0; wb_data = 19'h0; flush = 1'b0; ex_hold = 1'b0;

      // Reset state
      step(); step();
      chk("rst_ex_valid", ex_valid, 1'b0);
      chk("rst_bubble_cnt", bubble_cnt, 8'd0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_ex_rs_data", ex_rs_data, 19'h0);
      rst_n = 1'b1;

      // Normal flow
      id_valid = 1'b1; id_rs = 3'd2; id_rt = 3'd3; id_rd = 3'd4;
      id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_rs_data = 19'h12345;
      id_rt_data = 19'h00ABC; id_imm = 19'h00007; id_alu_op = 4'h3; id_regwrite = 1'b1;
      #1;
      chk("norm_stall_pre", stall, 1'b0);
      step();
      chk("norm_ex_valid", ex_valid, 1'b1);
      chk("norm_ex_rs", ex_rs, 3'd2);
      chk("norm_ex_rt", ex_rt, 3'd3);
      chk("norm_ex_rd", ex_rd, 3'd4);
      chk("norm_ex_rs_data", ex_rs_data, 19'h12345);
      chk("norm_ex_imm", ex_imm, 19'h00007);
      chk("norm_ex_alu_op", ex_alu_op, 4'h3);
      chk("norm_ex_regwrite", ex_regwrite, 1'b1);
      chk("norm_stall", stall, 1'b0);

      // Load-use: one stall cycle, one bubble, then the consumer
      drive_load();
      step();
      chk("lu_load_memread", ex_memread, 1'b1);
      drive_consumer(1'b1);
      #1;
      chk("lu_stall", stall, 1'b1);
      step();
      chk("lu_bub_valid", ex_valid, 1'b0);
      chk("lu_bub_regwrite", ex_regwrite, 1'b0);
      chk("lu_bub_rd", ex_rd, 3'd0);
      chk("lu_bub_data_kept", ex_rs_data, 19'h00AAA);
      chk("lu_bub_cnt", bubble_cnt, 8'd1);
      chk("lu_stall_after", stall, 1'b0);
      step();
      chk("lu_cons_valid", ex_valid, 1'b1);
      chk("lu_cons_rs", ex_rs, 3'd5);
      chk("lu_cons_rd", ex_rd, 3'd7);
      chk("lu_cons_rs_data", ex_rs_data, 19'h00111);
      chk("lu_cons_cnt", bubble_cnt, 8'd1);

      // Same pair, but the consumer does not read rs: no stall
      drive_load();
      step();
      drive_consumer(1'b0);
      #1;
      chk("nouse_stall", stall, 1'b0);
      step();
      chk("nouse_ex_valid", ex_valid, 1'b1);
      chk("nouse_ex_rd", ex_rd, 3'd7);
      chk("nouse_cnt", bubble_cnt, 8'd1);

      // WB bypass
      id_valid = 1'b1; id_rs = 3'd1; id_rt = 3'd3; id_rd = 3'd2;
      id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_rs_data = 19'h00222; id_rt_data = 19'h00000;
      id_memread = 1'b0; id_memtoreg = 1'b0;
      wb_regwrite = 1'b1; wb_rd = 3'd3; wb_data = 19'h7FFFF;
      step();
      chk("byp_rt_data", ex_rt_data, 19'h7FFFF);
      chk("byp_rs_untouched", ex_rs_data, 19'h00222);
      wb_regwrite = 1'b0;
      step();
      chk("byp_off_rt_data", ex_rt_data, 19'h00000);
      // bypass applies even when the operand is not used
      id_uses_rs = 1'b0; wb_regwrite = 1'b1; wb_rd = 3'd1; wb_data = 19'h5A5A5;
      step();
      chk("byp_unused_rs", ex_rs_data, 19'h5A5A5);
      wb_regwrite = 1'b0;

      // Invalid instruction: write/mem controls forced low
      id_valid = 1'b0; id_regwrite = 1'b1; id_memwrite = 1'b1; id_memread = 1'b1;
      id_memtoreg = 1'b1; id_alu_op = 4'h9;
      step();
      chk("inv_valid", ex_valid, 1'b0);
      chk("inv_regwrite", ex_regwrite, 1'b0);
      chk("inv_memwrite", ex_memwrite, 1'b0);
      chk("inv_memread", ex_memread, 1'b0);
      chk("inv_alu_op", ex_alu_op, 4'h9);

      // Flush with hazard and hold: flush wins, uncounted bubble
      drive_load();
      step();
      drive_consumer(1'b1);
      flush = 1'b1; ex_hold = 1'b1;
      #1;
      chk("fl_stall", stall, 1'b0);
      step();
      chk("fl_ex_valid", ex_valid, 1'b0);
      chk("fl_ex_memread", ex_memread, 1'b0);
      chk("fl_cnt", bubble_cnt, 8'd1);
      flush = 1'b0; ex_hold = 1'b0;

      // Hold for 3 cycles during a hazard
      drive_load();
      step();
      drive_consumer(1'b1);
      ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_ex_valid", ex_valid, 1'b1);
         chk("hold_ex_rd", ex_rd, 3'd5);
         chk("hold_ex_memread", ex_memread, 1'b1);
         chk("hold_stall", stall, 1'b1);
      end
      ex_hold = 1'b0;
      step();
      chk("hold_rel_bubble", ex_valid, 1'b0);
      chk("hold_rel_cnt", bubble_cnt, 8'd2);
      step();
      chk("hold_rel_cons", ex_rd, 3'd7);

      // Reset mid-stall
      drive_load();
      step();
      drive_consumer(1'b1);
      #1;
      chk("rs_stall_pre", stall, 1'b1);
      rst_n = 1'b0;
      step();
      chk("rs_ex_valid", ex_valid, 1'b0);
      chk("rs_ex_rd", ex_rd, 3'd0);
      chk("rs_ex_memread", ex_memread, 1'b0);
      chk("rs_ex_rs_data", ex_rs_data, 19'h0);
      chk("rs_cnt", bubble_cnt, 8'd0);
      chk("rs_stall", stall, 1'b0);
      rst_n = 1'b1;

      // Saturation: a load reading its own destination alternates load/bubble
      drive_load();
      id_rs = 3'd5;
      for (int i = 0; i < 508; i++) step();
      chk("sat_254", bubble_cnt, 8'd254);
      for (int i = 0; i < 92; i++) step();
      chk("sat_255", bubble_cnt, 8'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
